// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: default widths (shared
// with WriteBack), state encodings and a small decode helper.
package mem_access_pkg;

   localparam int MA_DATA_W         = 8;
   localparam int MA_ADDR_W         = 8;
   localparam int MA_REG_AW         = 4;
   localparam int MA_TIMEOUT_CYCLES = 16;

   typedef enum logic {
      MA_IDLE = 1'b0,
      MA_WAIT = 1'b1
   } ma_state_e;

   // A load and a store both need the memory port.
   function automatic logic is_mem_op(input logic rd, input logic wr);
      return rd | wr;
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Watchdog counter for outstanding memory transactions.
// Only present when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_ctr #(
   parameter int LIMIT = 16
)(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Clear on entry to WAIT, otherwise count WAIT cycles without ack.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // The current WAIT cycle is the LIMIT-th one.
   assign expired = (count_q == LAST);

endmodule
`endif

// File: rtl/mem_access.sv
// Memory-access pipeline stage. ALU results pass through in one cycle;
// loads/stores run a req/ack handshake and stall upstream until ack.
// Optional feature: MEM_TIMEOUT_EN aborts a transaction after
// TIMEOUT_CYCLES WAIT cycles without ack and pulses mem_fault.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int DATA_W = MA_DATA_W,
   parameter int ADDR_W = MA_ADDR_W,
   parameter int REG_AW = MA_REG_AW,
   parameter int TIMEOUT_CYCLES = MA_TIMEOUT_CYCLES
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              writeReg_e,
   input  logic [REG_AW-1:0] dst_e,
   input  logic [DATA_W-1:0] aluOut_e,
   input  logic [DATA_W-1:0] storeData_e,
   input  logic              memRead_e,
   input  logic              memWrite_e,
   output logic              stall_m,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              mem_fault,
   output logic              writeReg_m,
   output logic [REG_AW-1:0] dst_m,
   output logic [DATA_W-1:0] regData_m
);

   ma_state_e         state_q, state_d;
   logic              hold_wr_q, hold_wr_d;
   logic [REG_AW-1:0] hold_dst_q, hold_dst_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              write_reg_m_q, write_reg_m_d;
   logic [REG_AW-1:0] dst_m_q, dst_m_d;
   logic [DATA_W-1:0] reg_data_m_q, reg_data_m_d;
   logic              mem_op;

   assign mem_op = is_mem_op(memRead_e, memWrite_e);

`ifdef MEM_TIMEOUT_EN
   logic mem_fault_q, mem_fault_d;
   logic tmo_expired;

   mem_timeout_ctr #(
      .LIMIT   (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   ((state_q == MA_IDLE) && mem_op),
      .inc     ((state_q == MA_WAIT) && !mem_ack),
      .expired (tmo_expired)
   );

   assign mem_fault = mem_fault_q;
`else
   assign mem_fault = 1'b0;
`endif

   // Next-state, handshake and WriteBack decode; stall_m is combinational.
   always_comb begin
      state_d       = state_q;
      hold_wr_d     = hold_wr_q;
      hold_dst_d    = hold_dst_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      write_reg_m_d = 1'b0;
      dst_m_d       = dst_m_q;
      reg_data_m_d  = reg_data_m_q;
      stall_m       = 1'b0;
`ifdef MEM_TIMEOUT_EN
      mem_fault_d   = 1'b0;
`endif
      unique case (state_q)
         MA_IDLE: begin
            if (mem_op) begin
               // Launch the transaction; a simultaneous read+write is a store.
               stall_m     = 1'b1;
               hold_wr_d   = writeReg_e;
               hold_dst_d  = dst_e;
               mem_req_d   = 1'b1;
               mem_we_d    = memWrite_e;
               mem_addr_d  = aluOut_e[ADDR_W-1:0];
               mem_wdata_d = storeData_e;
               state_d     = MA_WAIT;
            end else begin
               write_reg_m_d = writeReg_e;
               dst_m_d       = dst_e;
               reg_data_m_d  = aluOut_e;
            end
         end
         MA_WAIT: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = MA_IDLE;
               if (!mem_we_q) begin
                  write_reg_m_d = hold_wr_q;
                  dst_m_d       = hold_dst_q;
                  reg_data_m_d  = mem_rdata;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (tmo_expired) begin
               // Abort: release the pipeline and flag the fault.
               mem_req_d   = 1'b0;
               state_d     = MA_IDLE;
               mem_fault_d = 1'b1;
            end
`endif
            else begin
               stall_m = 1'b1;
            end
         end
         default: state_d = MA_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= MA_IDLE;
         hold_wr_q     <= 1'b0;
         hold_dst_q    <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         write_reg_m_q <= 1'b0;
         dst_m_q       <= '0;
         reg_data_m_q  <= '0;
`ifdef MEM_TIMEOUT_EN
         mem_fault_q   <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         hold_wr_q     <= hold_wr_d;
         hold_dst_q    <= hold_dst_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         write_reg_m_q <= write_reg_m_d;
         dst_m_q       <= dst_m_d;
         reg_data_m_q  <= reg_data_m_d;
`ifdef MEM_TIMEOUT_EN
         mem_fault_q   <= mem_fault_d;
`endif
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign writeReg_m = write_reg_m_q;
   assign dst_m      = dst_m_q;
   assign regData_m  = reg_data_m_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access: ALU pass-through, loads, stores,
// reset during a transaction, back-to-back ops and (with MEM_TIMEOUT_EN)
// the timeout abort.
module tb_mem_access;

   logic       clk = 1'b0;
   logic       rst;
   logic       writeReg_e;
   logic [3:0] dst_e;
   logic [7:0] aluOut_e;
   logic [7:0] storeData_e;
   logic       memRead_e;
   logic       memWrite_e;
   logic       stall_m;
   logic       mem_req;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic [7:0] mem_rdata;
   logic       mem_ack;
   logic       mem_fault;
   logic       writeReg_m;
   logic [3:0] dst_m;
   logic [7:0] regData_m;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access #(.TIMEOUT_CYCLES(4)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .writeReg_e  (writeReg_e),
      .dst_e       (dst_e),
      .aluOut_e    (aluOut_e),
      .storeData_e (storeData_e),
      .memRead_e   (memRead_e),
      .memWrite_e  (memWrite_e),
      .stall_m     (stall_m),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .mem_fault   (mem_fault),
      .writeReg_m  (writeReg_m),
      .dst_m       (dst_m),
      .regData_m   (regData_m)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      writeReg_e  = 1'b0;
      dst_e       = 4'd0;
      aluOut_e    = 8'h00;
      storeData_e = 8'h00;
      memRead_e   = 1'b0;
      memWrite_e  = 1'b0;
   endtask

   task automatic check_wb(input string tag, input logic wr, input logic [3:0] dst,
                           input logic [7:0] data);
      chk({tag, ".writeReg_m"}, 32'(writeReg_m), 32'(wr));
      if (wr) begin
         chk({tag, ".dst_m"}, 32'(dst_m), 32'(dst));
         chk({tag, ".regData_m"}, 32'(regData_m), 32'(data));
      end
   endtask

   task automatic check_mem(input string tag, input logic req, input logic we,
                            input logic [7:0] addr, input logic [7:0] wdata);
      chk({tag, ".mem_req"}, 32'(mem_req), 32'(req));
      chk({tag, ".mem_we"}, 32'(mem_we), 32'(we));
      chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
      chk({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(wdata));
   endtask

   task automatic check_stall(input string tag, input logic exp);
      #1;
      chk({tag, ".stall_m"}, 32'(stall_m), 32'(exp));
   endtask

   // Global time bound so the bench can never hang.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      idle_inputs();
      step();
      step();

      // Reset state
      $display("[%0t] reset state", $time);
      check_mem("rst", 1'b0, 1'b0, 8'h00, 8'h00);
      check_wb("rst", 1'b0, 4'd0, 8'h00);
      chk("rst.dst_m", 32'(dst_m), 32'd0);
      chk("rst.regData_m", 32'(regData_m), 32'd0);
      chk("rst.mem_fault", 32'(mem_fault), 32'd0);
      check_stall("rst", 1'b0);
      rst = 1'b0;

      // ALU op: one-cycle pass-through, no stall
      $display("[%0t] ALU dst=3 aluOut=5A", $time);
      writeReg_e = 1'b1; dst_e = 4'd3; aluOut_e = 8'h5A;
      check_stall("alu", 1'b0);
      step();
      check_wb("alu", 1'b1, 4'd3, 8'h5A);
      idle_inputs();
      check_stall("alu.after", 1'b0);
      step();
      check_wb("alu.bubble", 1'b0, 4'd0, 8'h00);

      // Load addr 10, dst 7, ack in the 4th WAIT cycle with rdata C3
      $display("[%0t] LOAD addr=10 dst=7 rdata=C3 late ack", $time);
      memRead_e = 1'b1; writeReg_e = 1'b1; dst_e = 4'd7; aluOut_e = 8'h10;
      check_stall("ld.idle", 1'b1);
      step();
      for (int i = 1; i <= 3; i++) begin
         check_mem("ld.wait", 1'b1, 1'b0, 8'h10, 8'h00);
         check_wb("ld.wait", 1'b0, 4'd0, 8'h00);
         chk("ld.wait.mem_fault", 32'(mem_fault), 32'd0);
         check_stall("ld.wait", 1'b1);
         step();
      end
      mem_ack = 1'b1; mem_rdata = 8'hC3;
      check_stall("ld.ack", 1'b0);
      chk("ld.ack.mem_req", 32'(mem_req), 32'd1);
      step();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      idle_inputs();
      check_wb("ld.done", 1'b1, 4'd7, 8'hC3);
      chk("ld.done.mem_req", 32'(mem_req), 32'd0);
      check_stall("ld.done", 1'b0);
      step();
      check_wb("ld.once", 1'b0, 4'd0, 8'h00);

      // Store addr 20, data 99, ack in first WAIT cycle
      $display("[%0t] STORE addr=20 data=99", $time);
      memWrite_e = 1'b1; writeReg_e = 1'b1; dst_e = 4'd5;
      aluOut_e = 8'h20; storeData_e = 8'h99;
      check_stall("st.idle", 1'b1);
      step();
      check_mem("st.wait", 1'b1, 1'b1, 8'h20, 8'h99);
      check_wb("st.wait", 1'b0, 4'd0, 8'h00);
      mem_ack = 1'b1;
      check_stall("st.ack", 1'b0);
      step();
      mem_ack = 1'b0;
      idle_inputs();
      chk("st.done.mem_req", 32'(mem_req), 32'd0);
      check_wb("st.done", 1'b0, 4'd0, 8'h00);

      // Read and write together: treated as a store
      $display("[%0t] READ+WRITE addr=21 data=3C", $time);
      memRead_e = 1'b1; memWrite_e = 1'b1; writeReg_e = 1'b1; dst_e = 4'd6;
      aluOut_e = 8'h21; storeData_e = 8'h3C;
      step();
      check_mem("rw.wait", 1'b1, 1'b1, 8'h21, 8'h3C);
      mem_ack = 1'b1; mem_rdata = 8'hAA;
      check_stall("rw.ack", 1'b0);
      step();
      mem_ack = 1'b0;
      idle_inputs();
      check_wb("rw.done", 1'b0, 4'd0, 8'h00);
      chk("rw.done.mem_req", 32'(mem_req), 32'd0);

      // Reset in the 2nd WAIT cycle of a load, then a late ack
      $display("[%0t] LOAD addr=44 dst=9 reset mid-transaction", $time);
      memRead_e = 1'b1; writeReg_e = 1'b1; dst_e = 4'd9; aluOut_e = 8'h44;
      step();
      check_stall("rl.wait1", 1'b1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      idle_inputs();
      check_mem("rl.rst", 1'b0, 1'b0, 8'h00, 8'h00);
      check_wb("rl.rst", 1'b0, 4'd0, 8'h00);
      chk("rl.rst.dst_m", 32'(dst_m), 32'd0);
      chk("rl.rst.regData_m", 32'(regData_m), 32'd0);
      mem_ack = 1'b1; mem_rdata = 8'hEE;
      check_stall("rl.lateack", 1'b0);
      step();
      check_wb("rl.lateack", 1'b0, 4'd0, 8'h00);
      chk("rl.lateack.mem_req", 32'(mem_req), 32'd0);

      // Stray ack in IDLE during an ALU op is ignored
      $display("[%0t] ALU dst=8 aluOut=42 with stray ack", $time);
      writeReg_e = 1'b1; dst_e = 4'd8; aluOut_e = 8'h42;
      check_stall("ia", 1'b0);
      step();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      idle_inputs();
      check_wb("ia", 1'b1, 4'd8, 8'h42);
      chk("ia.mem_req", 32'(mem_req), 32'd0);

      // Back-to-back load then ALU op
      $display("[%0t] LOAD addr=30 dst=2 then ALU dst=4 aluOut=11", $time);
      memRead_e = 1'b1; writeReg_e = 1'b1; dst_e = 4'd2; aluOut_e = 8'h30;
      step();
      check_mem("bb.wait", 1'b1, 1'b0, 8'h30, 8'h00);
      mem_ack = 1'b1; mem_rdata = 8'h77;
      check_stall("bb.ack", 1'b0);
      step();
      mem_ack = 1'b0; mem_rdata = 8'h00;
      check_wb("bb.load", 1'b1, 4'd2, 8'h77);
      memRead_e = 1'b0; writeReg_e = 1'b1; dst_e = 4'd4; aluOut_e = 8'h11;
      check_stall("bb.alu", 1'b0);
      step();
      idle_inputs();
      check_wb("bb.alu", 1'b1, 4'd4, 8'h11);
      step();
      check_wb("bb.end", 1'b0, 4'd0, 8'h00);

`ifdef MEM_TIMEOUT_EN
      // Timeout: no ack, limit of 4 WAIT cycles
      $display("[%0t] LOAD addr=50 dst=1 no ack (timeout)", $time);
      memRead_e = 1'b1; writeReg_e = 1'b1; dst_e = 4'd1; aluOut_e = 8'h50;
      step();
      for (int i = 1; i <= 3; i++) begin
         chk("to.wait.mem_fault", 32'(mem_fault), 32'd0);
         check_stall("to.wait", 1'b1);
         step();
      end
      check_stall("to.limit", 1'b0);
      chk("to.limit.mem_req", 32'(mem_req), 32'd1);
      step();
      idle_inputs();
      chk("to.abort.mem_fault", 32'(mem_fault), 32'd1);
      chk("to.abort.mem_req", 32'(mem_req), 32'd0);
      check_wb("to.abort", 1'b0, 4'd0, 8'h00);
      check_stall("to.abort", 1'b0);
      step();
      chk("to.pulse.mem_fault", 32'(mem_fault), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
